// File: rtl/fp_addsub_pipe_ctl.sv
// fp_addsub_pipe_ctl
//   Multi-cycle IEEE-754 binary add/subtract for any EXP_W/MAN_W format.
//   One operation in flight; fixed latency of six cycles from accept to
//   out_valid, special operands included.
// Ports
//   clk, reset_n         : clock, asynchronous active-low reset
//   in_valid/in_ready    : operand handshake (in_ready only in IDLE)
//   op_a, op_b, sub      : operands; sub=1 computes op_a - op_b
//   rnd_mode             : 00 RNE, 01 RTZ, 10 RDN, 11 RUP
//   out_valid/out_ready  : result handshake; result/flags hold while stalled
//   result, flags        : rounded result, {invalid, overflow, underflow, inexact}
module fp_addsub_pipe_ctl #(
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [EXP_W+MAN_W:0]   op_a,
   input  logic [EXP_W+MAN_W:0]   op_b,
   input  logic                   sub,
   input  logic [1:0]             rnd_mode,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [EXP_W+MAN_W:0]   result,
   output logic [3:0]             flags
);
   localparam int W  = 1 + EXP_W + MAN_W;
   localparam int F  = MAN_W + 4;          // {hidden, frac, G, R, S}
   localparam int EW = EXP_W + 1;          // room for carry and round-up
   localparam int SW = $clog2(F + 1);
   localparam logic [1:0] RNE = 2'b00, RDN = 2'b10, RUP = 2'b11;
   localparam logic [W-1:0] QNAN = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

   typedef enum logic [2:0] {IDLE, UNPACK, ALIGN, ADD, NORM, ROUND, OUT} state_t;
   state_t state_q, state_d;

   logic [W-1:0]   a_q, a_d, b_q, b_d;
   logic [1:0]     rm_q, rm_d;
   logic [EW-1:0]  ea_q, ea_d, eb_q, eb_d, exp_q, exp_d;
   logic [MAN_W:0] ma_q, ma_d, mb_q, mb_d;
   logic           spec_q, spec_d, sign_q, sign_d, eff_sub_q, eff_sub_d, zero_q, zero_d;
   logic [W-1:0]   spec_res_q, spec_res_d, pk_res_q, pk_res_d, result_q, result_d;
   logic [3:0]     spec_flg_q, spec_flg_d, pk_flg_q, pk_flg_d, flags_q, flags_d;
   logic [F-1:0]   fa_q, fa_d, fb_q, fb_d, nm_q, nm_d;
   logic [F:0]     sum_q, sum_d;
   logic           out_valid_q, out_valid_d;

   // ---------------- next-state ----------------
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (in_valid) state_d = UNPACK;
         UNPACK:  state_d = ALIGN;
         ALIGN:   state_d = ADD;
         ADD:     state_d = NORM;
         NORM:    state_d = ROUND;
         ROUND:   state_d = OUT;
         OUT:     if (out_valid_q && out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // ---------------- outputs ----------------
   always_comb begin
      in_ready  = (state_q == IDLE) && reset_n;
      out_valid = out_valid_q;
      result    = result_q;
      flags     = flags_q;
   end

   // ---------------- datapath ----------------
   logic [EXP_W-1:0] fea, feb;
   logic [MAN_W-1:0] fra, frb;
   logic             a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
   logic             a_ge, s_s;
   logic [EW-1:0]    e_l, e_s, e_diff, lim, exp_r;
   logic [MAN_W:0]   m_l, m_s, man_r;
   logic [SW-1:0]    dsh, lzc, sh;
   logic [2*F-1:0]   ext;
   logic             g, r, s, gx, inc, ovf, to_inf;
   logic [MAN_W+1:0] rnd;
   logic [W-1:0]     res_c;
   logic [3:0]       flg_c;

   always_comb begin
      // unpack / classify
      fea    = a_q[W-2:MAN_W];
      feb    = b_q[W-2:MAN_W];
      fra    = a_q[MAN_W-1:0];
      frb    = b_q[MAN_W-1:0];
      a_nan  = (&fea) && (|fra);
      b_nan  = (&feb) && (|frb);
      a_snan = a_nan && !fra[MAN_W-1];
      b_snan = b_nan && !frb[MAN_W-1];
      a_inf  = (&fea) && !(|fra);
      b_inf  = (&feb) && !(|frb);
      a_zero = !(|a_q[W-2:0]);
      b_zero = !(|b_q[W-2:0]);

      // align: larger magnitude becomes A, B shifted right with sticky
      a_ge   = {ea_q, ma_q} >= {eb_q, mb_q};
      e_l    = a_ge ? ea_q : eb_q;
      e_s    = a_ge ? eb_q : ea_q;
      m_l    = a_ge ? ma_q : mb_q;
      m_s    = a_ge ? mb_q : ma_q;
      s_s    = a_ge ? b_q[W-1] : a_q[W-1];
      e_diff = e_l - e_s;
      dsh    = (32'(e_diff) >= 32'(F)) ? SW'(F) : SW'(e_diff);
      ext    = {m_s, 3'b000, {F{1'b0}}} >> dsh;

      // normalize: leading-zero count, shift limited so exponent stays >= 1
      lzc = SW'(F);
      for (int i = 0; i < F; i++)
         if (sum_q[i]) lzc = SW'(F - 1 - i);
      lim = exp_q - EW'(1);
      sh  = (32'(lzc) <= 32'(lim)) ? lzc : SW'(lim);

      // round
      g  = nm_q[2];
      r  = nm_q[1];
      s  = nm_q[0];
      gx = g | r | s;
      case (rm_q)
         RNE:     inc = g & (r | s | nm_q[3]);
         RDN:     inc = sign_q & gx;
         RUP:     inc = !sign_q & gx;
         default: inc = 1'b0;
      endcase
      rnd = {1'b0, nm_q[F-1:3]} + (MAN_W+2)'(inc);
      if (rnd[MAN_W+1]) begin
         man_r = rnd[MAN_W+1:1];
         exp_r = exp_q + EW'(1);
      end else begin
         man_r = rnd[MAN_W:0];
         exp_r = exp_q;
      end
      ovf    = exp_r >= {1'b0, {EXP_W{1'b1}}};
      to_inf = (rm_q == RNE) || (rm_q == RUP && !sign_q) || (rm_q == RDN && sign_q);
      if (zero_q) begin
         res_c = {rm_q == RDN, {(W-1){1'b0}}};
         flg_c = 4'b0000;
      end else if (ovf) begin
         res_c = to_inf ? {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                        : {sign_q, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         flg_c = 4'b0101;
      end else begin
         // hidden bit clear after rounding means a subnormal: exponent field 0
         res_c = {sign_q, man_r[MAN_W] ? exp_r[EXP_W-1:0] : {EXP_W{1'b0}}, man_r[MAN_W-1:0]};
         flg_c = {2'b00, !man_r[MAN_W] && gx, gx};
      end
   end

   always_comb begin
      a_d = a_q;  b_d = b_q;  rm_d = rm_q;
      ea_d = ea_q;  eb_d = eb_q;  ma_d = ma_q;  mb_d = mb_q;
      spec_d = spec_q;  spec_res_d = spec_res_q;  spec_flg_d = spec_flg_q;
      sign_d = sign_q;  eff_sub_d = eff_sub_q;  exp_d = exp_q;
      fa_d = fa_q;  fb_d = fb_q;  sum_d = sum_q;  nm_d = nm_q;  zero_d = zero_q;
      pk_res_d = pk_res_q;  pk_flg_d = pk_flg_q;
      result_d = result_q;  flags_d = flags_q;  out_valid_d = out_valid_q;
      case (state_q)
         IDLE: if (in_valid) begin
            a_d  = op_a;
            b_d  = {op_b[W-1] ^ sub, op_b[W-2:0]};
            rm_d = rnd_mode;
         end
         UNPACK: begin
            ea_d = (|fea) ? {1'b0, fea} : EW'(1);
            eb_d = (|feb) ? {1'b0, feb} : EW'(1);
            ma_d = {|fea, fra};
            mb_d = {|feb, frb};
            spec_d     = 1'b1;
            spec_flg_d = 4'b0000;
            if (a_nan || b_nan) begin
               spec_res_d = QNAN;
               spec_flg_d = {a_snan | b_snan, 3'b000};
            end else if (a_inf && b_inf && (a_q[W-1] != b_q[W-1])) begin
               spec_res_d = QNAN;
               spec_flg_d = 4'b1000;
            end else if (a_inf)  spec_res_d = a_q;
            else if (b_inf)      spec_res_d = b_q;
            else if (a_zero && b_zero)
               spec_res_d = {(a_q[W-1] == b_q[W-1]) ? a_q[W-1] : (rm_q == RDN), {(W-1){1'b0}}};
            else if (a_zero)     spec_res_d = b_q;
            else if (b_zero)     spec_res_d = a_q;
            else begin
               spec_d     = 1'b0;
               spec_res_d = '0;
            end
         end
         ALIGN: begin
            exp_d     = e_l;
            sign_d    = a_ge ? a_q[W-1] : b_q[W-1];
            eff_sub_d = (a_ge ? a_q[W-1] : b_q[W-1]) ^ s_s;
            fa_d      = {m_l, 3'b000};
            fb_d      = {ext[2*F-1:F+1], ext[F] | (|ext[F-1:0])};
         end
         ADD: sum_d = eff_sub_q ? ({1'b0, fa_q} - {1'b0, fb_q}) : ({1'b0, fa_q} + {1'b0, fb_q});
         NORM: begin
            zero_d = !(|sum_q);
            if (sum_q[F]) begin
               nm_d  = {sum_q[F:2], |sum_q[1:0]};
               exp_d = exp_q + EW'(1);
            end else begin
               nm_d  = sum_q[F-1:0] << sh;
               exp_d = exp_q - EW'(sh);
            end
         end
         ROUND: begin
            pk_res_d = spec_q ? spec_res_q : res_c;
            pk_flg_d = spec_q ? spec_flg_q : flg_c;
         end
         OUT: begin
            if (!out_valid_q) begin
               result_d    = pk_res_q;
               flags_d     = pk_flg_q;
               out_valid_d = 1'b1;
            end else if (out_ready) begin
               out_valid_d = 1'b0;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;  a_q <= '0;  b_q <= '0;  rm_q <= '0;
         ea_q <= '0;  eb_q <= '0;  ma_q <= '0;  mb_q <= '0;
         spec_q <= 1'b0;  spec_res_q <= '0;  spec_flg_q <= '0;
         sign_q <= 1'b0;  eff_sub_q <= 1'b0;  exp_q <= '0;
         fa_q <= '0;  fb_q <= '0;  sum_q <= '0;  nm_q <= '0;  zero_q <= 1'b0;
         pk_res_q <= '0;  pk_flg_q <= '0;
         result_q <= '0;  flags_q <= '0;  out_valid_q <= 1'b0;
      end else begin
         state_q <= state_d;  a_q <= a_d;  b_q <= b_d;  rm_q <= rm_d;
         ea_q <= ea_d;  eb_q <= eb_d;  ma_q <= ma_d;  mb_q <= mb_d;
         spec_q <= spec_d;  spec_res_q <= spec_res_d;  spec_flg_q <= spec_flg_d;
         sign_q <= sign_d;  eff_sub_q <= eff_sub_d;  exp_q <= exp_d;
         fa_q <= fa_d;  fb_q <= fb_d;  sum_q <= sum_d;  nm_q <= nm_d;  zero_q <= zero_d;
         pk_res_q <= pk_res_d;  pk_flg_q <= pk_flg_d;
         result_q <= result_d;  flags_q <= flags_d;  out_valid_q <= out_valid_d;
      end
   end
endmodule

// File: tb/tb_fp_addsub_pipe_ctl.sv
// Scoreboard bench for fp_addsub_pipe_ctl (float32 defaults). Stimulus pushes
// hand-computed expectations; a negedge monitor pops on each output handshake.
module tb_fp_addsub_pipe_ctl;
   logic        clk = 1'b0, reset_n = 1'b0, in_valid = 1'b0, sub = 1'b0, out_ready = 1'b1;
   logic [1:0]  rnd_mode = 2'b00;
   logic [31:0] op_a = '0, op_b = '0;
   logic        in_ready, out_valid;
   logic [31:0] result;
   logic [3:0]  flags;

   int n_chk = 0, n_fail = 0, cyc = 0;
   logic [35:0] exp_q[$];
   int          acc_q[$];
   string       lbl_q[$];
   bit          seen = 1'b0;

   fp_addsub_pipe_ctl #(.EXP_W(8), .MAN_W(23)) dut (
      .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
      .op_a(op_a), .op_b(op_b), .sub(sub), .rnd_mode(rnd_mode),
      .out_valid(out_valid), .out_ready(out_ready), .result(result), .flags(flags));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic void chk(string nm, logic [31:0] act, logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, req);
      end
   endfunction

   function automatic void fail_now(string nm);
      n_chk++;
      n_fail++;
      $display("FAIL %s", nm);
   endfunction

   // monitor: latency on rising out_valid, result/flags on handshake
   always @(negedge clk) begin
      logic [35:0] e;
      string nm;
      if (reset_n && out_valid) begin
         if (!seen) begin
            seen = 1'b1;
            if (acc_q.size() == 0) fail_now("unexpected out_valid");
            else chk({lbl_q[0], " latency"}, 32'(cyc - acc_q[0]), 32'd6);
         end
         if (out_ready) begin
            seen = 1'b0;
            if (exp_q.size() == 0) fail_now("unexpected result");
            else begin
               e  = exp_q.pop_front();
               nm = lbl_q.pop_front();
               void'(acc_q.pop_front());
               chk({nm, " result"}, result, e[35:4]);
               chk({nm, " flags"}, 32'(flags), 32'(e[3:0]));
            end
         end
      end
   end

   task automatic issue(string nm, logic [31:0] a, logic [31:0] b, logic s,
                        logic [1:0] rm, logic [31:0] er, logic [3:0] ef);
      int n = 0;
      @(posedge clk); #1;
      op_a = a; op_b = b; sub = s; rnd_mode = rm; in_valid = 1'b1;
      while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
      if (!in_ready) begin
         fail_now({nm, " accept timeout"});
         in_valid = 1'b0;
         return;
      end
      exp_q.push_back({er, ef});
      acc_q.push_back(cyc + 1);
      lbl_q.push_back(nm);
      @(posedge clk); #1;
      // scramble inputs: captured values must be used from here on
      in_valid = 1'b0; op_a = $urandom; op_b = $urandom; sub = 1'b1; rnd_mode = 2'b01;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() > 0 && n < 200) begin @(negedge clk); n++; end
      if (exp_q.size() > 0) begin
         fail_now("drain timeout");
         exp_q.delete(); acc_q.delete(); lbl_q.delete();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL global timeout");
      $fatal(1, "timeout");
   end

   initial begin
      int n;
      #12;
      chk("reset out_valid", 32'(out_valid), 0);
      chk("reset result", result, 0);
      chk("reset flags", 32'(flags), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("reset in_ready", 32'(in_ready), 1);

      issue("1+2",        32'h3F800000, 32'h40000000, 0, 2'b00, 32'h40400000, 4'b0000);
      issue("1-1 rne",    32'h3F800000, 32'h3F800000, 1, 2'b00, 32'h00000000, 4'b0000);
      issue("1-1 rtz",    32'h3F800000, 32'h3F800000, 1, 2'b01, 32'h00000000, 4'b0000);
      issue("1-1 rup",    32'h3F800000, 32'h3F800000, 1, 2'b11, 32'h00000000, 4'b0000);
      issue("1-1 rdn",    32'h3F800000, 32'h3F800000, 1, 2'b10, 32'h80000000, 4'b0000);
      issue("ovf rne",    32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b00, 32'h7F800000, 4'b0101);
      issue("ovf rtz",    32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b01, 32'h7F7FFFFF, 4'b0101);
      issue("ovf rup",    32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b11, 32'h7F800000, 4'b0101);
      issue("ovf rdn",    32'h7F7FFFFF, 32'h7F7FFFFF, 0, 2'b10, 32'h7F7FFFFF, 4'b0101);
      issue("novf rdn",   32'hFF7FFFFF, 32'hFF7FFFFF, 0, 2'b10, 32'hFF800000, 4'b0101);
      issue("inf-inf",    32'h7F800000, 32'hFF800000, 0, 2'b00, 32'h7FC00000, 4'b1000);
      issue("snan",       32'h7F800001, 32'h3F800000, 0, 2'b00, 32'h7FC00000, 4'b1000);
      issue("qnan",       32'h7FC00000, 32'h3F800000, 0, 2'b00, 32'h7FC00000, 4'b0000);
      issue("inf+1",      32'h7F800000, 32'h3F800000, 0, 2'b00, 32'h7F800000, 4'b0000);
      issue("tie even",   32'h3F800000, 32'h33800000, 0, 2'b00, 32'h3F800000, 4'b0001);
      issue("tie odd",    32'h3F800001, 32'h33800000, 0, 2'b00, 32'h3F800002, 4'b0001);
      issue("tie rup",    32'h3F800000, 32'h33800000, 0, 2'b11, 32'h3F800001, 4'b0001);
      issue("tie rdn",    32'h3F800000, 32'h33800000, 0, 2'b10, 32'h3F800000, 4'b0001);
      issue("sub+sub",    32'h00000001, 32'h00000001, 0, 2'b00, 32'h00000002, 4'b0000);
      issue("min-sub",    32'h00800000, 32'h00000001, 1, 2'b00, 32'h007FFFFF, 4'b0000);
      issue("2-1",        32'h40000000, 32'h3F800000, 1, 2'b00, 32'h3F800000, 4'b0000);
      issue("-0+-0",      32'h80000000, 32'h80000000, 0, 2'b00, 32'h80000000, 4'b0000);
      issue("0+1",        32'h00000000, 32'h3F800000, 0, 2'b00, 32'h3F800000, 4'b0000);
      drain();

      // output stall: hold result, block a second request
      out_ready = 1'b0;
      issue("stall", 32'h3F800000, 32'h40000000, 0, 2'b00, 32'h40400000, 4'b0000);
      n = 0;
      while (!out_valid && n < 20) begin @(negedge clk); n++; end
      if (!out_valid) fail_now("stall out_valid timeout");
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; op_a = 32'h7F800000; op_b = 32'h3F800000;
         @(negedge clk);
         chk("stall out_valid", 32'(out_valid), 1);
         chk("stall result", result, 32'h40400000);
         chk("stall in_ready", 32'(in_ready), 0);
      end
      @(posedge clk); #1;
      in_valid = 1'b0; out_ready = 1'b1;
      drain();
      repeat (10) @(negedge clk);
      chk("stall no second op", 32'(out_valid), 0);

      // reset during ALIGN aborts the operation
      @(posedge clk); #1;
      op_a = 32'h3F800000; op_b = 32'h40000000; sub = 1'b0; rnd_mode = 2'b00; in_valid = 1'b1;
      @(posedge clk); #1 in_valid = 1'b0;   // accepted; now UNPACK
      @(posedge clk); #1 reset_n = 1'b0;    // now ALIGN
      #1;
      chk("abort out_valid", 32'(out_valid), 0);
      chk("abort result", result, 0);
      chk("abort flags", 32'(flags), 0);
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk);
      chk("abort in_ready", 32'(in_ready), 1);
      repeat (12) @(negedge clk);
      chk("abort no out_valid", 32'(out_valid), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
